// File: rtl/m81_pkg.sv
// Shared definitions for the m81 8:1 lane-select mux: lane count, select width and lane codes.
package m81_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t LANE0 = 3'd0;
    localparam sel_t LANE1 = 3'd1;
    localparam sel_t LANE2 = 3'd2;
    localparam sel_t LANE3 = 3'd3;
    localparam sel_t LANE4 = 3'd4;
    localparam sel_t LANE5 = 3'd5;
    localparam sel_t LANE6 = 3'd6;
    localparam sel_t LANE7 = 3'd7;

endpackage

// File: rtl/m81_mux2.sv
// WIDTH-wide 2:1 combinational mux cell: y = sel ? b : a.
module m81_mux2 #(
    parameter int WIDTH = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = sel ? b : a;
    end

endmodule

// File: rtl/m81_mux.sv
// 8:1 WIDTH-bit mux built as a 3-level tree of 2:1 cells, followed by an output register.
module m81_mux
    import m81_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
    output logic [WIDTH-1:0] out
);

    sel_t             sel;
    logic [WIDTH-1:0] lvl1 [4];
    logic [WIDTH-1:0] lvl2 [2];
    logic [WIDTH-1:0] mux_next;

    always_comb begin
        sel = {S2, S1, S0};
    end

    // Level 1 pairs adjacent lanes on S0, level 2 on S1, level 3 on S2.
    m81_mux2 #(.WIDTH(WIDTH)) u_l1_0 (.sel(sel[0]), .a(D0), .b(D1), .y(lvl1[0]));
    m81_mux2 #(.WIDTH(WIDTH)) u_l1_1 (.sel(sel[0]), .a(D2), .b(D3), .y(lvl1[1]));
    m81_mux2 #(.WIDTH(WIDTH)) u_l1_2 (.sel(sel[0]), .a(D4), .b(D5), .y(lvl1[2]));
    m81_mux2 #(.WIDTH(WIDTH)) u_l1_3 (.sel(sel[0]), .a(D6), .b(D7), .y(lvl1[3]));

    m81_mux2 #(.WIDTH(WIDTH)) u_l2_0 (.sel(sel[1]), .a(lvl1[0]), .b(lvl1[1]), .y(lvl2[0]));
    m81_mux2 #(.WIDTH(WIDTH)) u_l2_1 (.sel(sel[1]), .a(lvl1[2]), .b(lvl1[3]), .y(lvl2[1]));

    m81_mux2 #(.WIDTH(WIDTH)) u_l3_0 (.sel(sel[2]), .a(lvl2[0]), .b(lvl2[1]), .y(mux_next));

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= RST_VAL;
        end else begin
            out <= mux_next;
        end
    end

endmodule

// File: tb/tb_m81_mux.sv
// Self-checking bench for m81_mux: a 1-bit and an 8-bit instance against an array-indexed reference.
module tb_m81_mux;

    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       d1 [8];
    logic [7:0] d8 [8];
    logic       out1;
    logic [7:0] out8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    m81_mux #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .D0(d1[0]), .D1(d1[1]), .D2(d1[2]), .D3(d1[3]),
        .D4(d1[4]), .D5(d1[5]), .D6(d1[6]), .D7(d1[7]),
        .S0(sel[0]), .S1(sel[1]), .S2(sel[2]),
        .out(out1)
    );

    m81_mux #(.WIDTH(8), .RST_VAL(RV8)) u_dut8 (
        .clk(clk), .rst(rst),
        .D0(d8[0]), .D1(d8[1]), .D2(d8[2]), .D3(d8[3]),
        .D4(d8[4]), .D5(d8[5]), .D6(d8[6]), .D7(d8[7]),
        .S0(sel[0]), .S1(sel[1]), .S2(sel[2]),
        .out(out8)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: whatever is at the inputs on the edge appears one cycle later.
    task automatic tick();
        logic       e1;
        logic [7:0] e8;
        @(posedge clk);
        e1 = rst ? 1'b0 : d1[sel];
        e8 = rst ? RV8  : d8[sel];
        #1;
        check("model_w1", {7'd0, out1}, {7'd0, e1});
        check("model_w8", out8, e8);
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < 8; i++) begin
            d1[i] = 1'b0;
            d8[i] = 8'h00;
        end
    endtask

    initial begin
        clear_lanes();

        // Reset with lane 7 selected and high
        rst = 1'b1;
        sel = 3'd7;
        d1[7] = 1'b1;
        d8[7] = 8'hFF;
        tick();
        check("rst_c1_w1", {7'd0, out1}, 8'h00);
        check("rst_c1_w8", out8, RV8);
        tick();
        check("rst_c2_w1", {7'd0, out1}, 8'h00);
        check("rst_c2_w8", out8, RV8);
        rst = 1'b0;
        tick();
        check("rst_rel_w1", {7'd0, out1}, 8'h01);
        check("rst_rel_w8", out8, 8'hFF);

        // Exhaustive one-hot select on the 1-bit instance
        for (int k = 0; k < 8; k++) begin
            clear_lanes();
            d1[k] = 1'b1;
            sel = 3'(k);
            tick();
            check("onehot_hit", {7'd0, out1}, 8'h01);
            sel = 3'((k + 1) % 8);
            tick();
            check("onehot_miss", {7'd0, out1}, 8'h00);
        end

        // Walking data with a one-cycle reset inserted mid-stream
        for (int i = 0; i < 8; i++) begin
            d8[i] = 8'(1 << i);
        end
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            tick();
            check("walk", out8, 8'(1 << k));
        end
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            rst = (k == 4);
            tick();
            check("walk_rst", out8, (k == 4) ? RV8 : 8'(1 << k));
        end
        rst = 1'b0;

        // Latency: a mid-cycle select change must not reach out before the edge
        clear_lanes();
        d8[5] = 8'h01;
        sel = 3'd0;
        tick();
        check("lat_before", out8, 8'h00);
        sel = 3'd5;
        #3;
        check("lat_mid", out8, 8'h00);
        tick();
        check("lat_after", out8, 8'h01);

        // Isolation: unselected lanes toggle, lane 3 held
        sel = 3'd3;
        d1[3] = 1'b1;
        d8[3] = 8'h01;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (i != 3) begin
                    d1[i] = ~d1[i];
                    d8[i] = ~d8[i];
                end
            end
            tick();
            check("iso_w1", {7'd0, out1}, 8'h01);
            check("iso_w8", out8, 8'h01);
        end

        // Random inputs with occasional reset
        for (int c = 0; c < 200; c++) begin
            sel = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 8; i++) begin
                d1[i] = 1'($urandom);
                d8[i] = 8'($urandom);
            end
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m81_mux.md
Name: m81_mux

Overview:
- 8:1 multiplexer with a registered output, WIDTH bits per data lane.
- Selects one of eight data inputs D0..D7 using the 3-bit code {S2,S1,S0}. S0 is the LSB.
- Used as a generic lane-select leaf cell in datapaths.
- The output is registered so that it can sit on timing-critical paths.

Parameters:
- WIDTH, 1, bit width of each data input and of out.
- RST_VAL, 0 (WIDTH bits), value loaded into out on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- D0  input  WIDTH  data lane 0, selected when {S2,S1,S0}=3'b000.
- D1  input  WIDTH  data lane 1 (3'b001).
- D2  input  WIDTH  data lane 2 (3'b010).
- D3  input  WIDTH  data lane 3 (3'b011).
- D4  input  WIDTH  data lane 4 (3'b100).
- D5  input  WIDTH  data lane 5 (3'b101).
- D6  input  WIDTH  data lane 6 (3'b110).
- D7  input  WIDTH  data lane 7 (3'b111).
- S0  input  1  select bit 0 (LSB).
- S1  input  1  select bit 1.
- S2  input  1  select bit 2 (MSB).
- out  output  WIDTH  registered selected lane.

Interface (already decided):
- One clock; reset is synchronous and active-high.
- Ports are named clk and rst.

Behaviour:
- Combinational stage: sel = {S2,S1,S0}; mux_next = D[sel]. Purely combinational, no latches. Every select code maps to exactly one lane; there is no default/X case.
- Register stage: at each rising clk edge:
  - if rst=1, out <= RST_VAL;
  - else out <= mux_next.
- Latency: exactly 1 clock from a change in D*/S* to a change in out. There is no combinational path from inputs to out.
- Reset:
  - out = RST_VAL (all zeros by default) on the first edge with rst high.
  - rst asserted mid-stream overrides whatever the select and data inputs are on that edge.
  - The edge after rst deasserts, out takes the lane selected at that edge.
- Simultaneous select and data changes: the value sampled is whatever {S2,S1,S0} and D* are at the edge. No glitch filtering and no hysteresis.
- Unselected lanes never affect out.
- X or Z on an unselected lane must not propagate to out.
- No handshake, no enable: out updates every cycle.
- Width rule: all lanes and out are WIDTH bits; no extension or truncation.

Decomposition:
- Shared package m81_pkg:
  - localparam NUM_LANES = 8;
  - localparam SEL_W = 3;
  - typedef of the 3-bit select code;
  - named constants LANE0..LANE7 = 3'd0..3'd7.
- One sub-module, m81_mux2: a WIDTH-wide 2:1 combinational mux (sel, a, b -> y).
- m81_mux instantiates seven m81_mux2 cells as a 3-level tree:
  - level 1 is driven by S0;
  - level 2 by S1;
  - level 3 by S2.
- The tree is followed by the output register in the top module.

Test Plan:
- Reset: drive rst=1 for 2 cycles with D7=1 and sel=3'b111 -> out=0 on both cycles. On the cycle after rst drops, out=1.
- Exhaustive select, WIDTH=1: set lane k=1 and all other lanes=0 for each k=0..7, with sel=k -> out=1 one cycle later. Sel=(k+1)%8 -> out=0.
- Walking-data, WIDTH=8: D0..D7 = 8'h01,8'h02,...,8'h80. Step sel 0..7 every cycle -> out follows 8'h01..8'h80, delayed exactly 1 cycle.
- Latency check: change sel from 3'b000 to 3'b101 between edges (D0=0, D5=1) -> out stays 0 until the next rising edge, then becomes 1. No mid-cycle change.
- Mid-stream reset: while cycling sel, assert rst for 1 cycle -> out=RST_VAL that cycle, then normal selection resumes on the next edge.
- Isolation: toggle all unselected lanes every cycle with sel fixed at 3'b011 and D3 held at 1 -> out holds 1 throughout.
